// File: rtl/stage_id_pipe.sv
// stage_id_pipe
// -------------
// Instruction-decode stage for an RV32 integer pipeline. It holds the
// architectural register file, decodes the incoming instruction into
// operands, a sign-extended immediate and control bits, detects load-use
// hazards against the instruction in ID/EX, and owns the ID/EX register.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid          instruction input is valid
//   instruction       RV32 instruction from fetch
//   flush             kill the instruction entering ID/EX (taken branch)
//   ex_hold           downstream stall, ID/EX keeps its contents
//   reg_write         writeback enable
//   write_reg         writeback register index
//   write_data        writeback data
//   stall             combinational, upstream holds instruction and PC
//   ex_valid          ID/EX holds a real instruction
//   ex_reg_data1/2    source operands
//   ex_immediate      sign-extended immediate
//   ex_rs1/rs2/rd     register indices
//   ex_funct          {instruction[30], funct3}
//   ex_RegWrite .. ex_Branch, ex_ULAOp   decoded control bits

module stage_id_pipe #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instruction,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [XLEN-1:0]   write_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_reg_data1,
  output logic [XLEN-1:0]   ex_reg_data2,
  output logic [XLEN-1:0]   ex_immediate,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [3:0]        ex_funct,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_MemtoReg,
  output logic              ex_ULASrc,
  output logic              ex_Branch,
  output logic [1:0]        ex_ULAOp
);

  localparam int NREG = 2 ** REG_AW;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [3:0]        funct;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_to_reg;
    logic              ula_src;
    logic              branch;
    logic [1:0]        ula_op;
  } idex_t;

  idex_t           idex_q, idex_d;
  idex_t           dec;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm_i, imm_s, imm_b;
  logic              hazard;

  // ---------------------------------------------------------------------
  // Field extraction and immediates
  // ---------------------------------------------------------------------
  always_comb begin
    opcode = instruction[6:0];
    rs1    = REG_AW'(instruction[19:15]);
    rs2    = REG_AW'(instruction[24:20]);
    rd     = REG_AW'(instruction[11:7]);
    imm_i  = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    imm_s  = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    imm_b  = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
              instruction[30:25], instruction[11:8], 1'b0};
  end

  // ---------------------------------------------------------------------
  // Register file next state; entry 0 is pinned to zero
  // ---------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    if (reg_write && (write_reg != '0)) begin
      regs_d[write_reg] = write_data;
    end
    regs_d[0] = '0;
  end

  // ---------------------------------------------------------------------
  // Decode of the instruction currently presented
  // ---------------------------------------------------------------------
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.rd    = rd;
    dec.funct = {instruction[30], instruction[14:12]};

    // Write-through so an instruction reading a register being written back
    // this cycle sees the new value without a separate bypass stage.
    if (reg_write && (write_reg != '0) && (write_reg == rs1)) begin
      dec.data1 = write_data;
    end else begin
      dec.data1 = regs_q[rs1];
    end
    if (reg_write && (write_reg != '0) && (write_reg == rs2)) begin
      dec.data2 = write_data;
    end else begin
      dec.data2 = regs_q[rs2];
    end

    unique case (opcode)
      OP_R: begin
        dec.reg_wr = 1'b1;
        dec.ula_op = 2'b10;
      end
      OP_LOAD: begin
        dec.reg_wr     = 1'b1;
        dec.mem_rd     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.ula_src    = 1'b1;
        dec.ula_op     = 2'b00;
        dec.imm        = imm_i;
      end
      OP_STORE: begin
        dec.mem_wr  = 1'b1;
        dec.ula_src = 1'b1;
        dec.ula_op  = 2'b00;
        dec.imm     = imm_s;
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        dec.ula_op = 2'b01;
        dec.imm    = imm_b;
      end
      OP_IMM: begin
        dec.reg_wr  = 1'b1;
        dec.ula_src = 1'b1;
        dec.ula_op  = 2'b11;
        dec.imm     = imm_i;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Load-use hazard and stall
  // ---------------------------------------------------------------------
  always_comb begin
    hazard = idex_q.valid && idex_q.mem_rd && (idex_q.rd != '0) && in_valid &&
             ((idex_q.rd == rs1) || (idex_q.rd == rs2));
    // A flush kills the dependent instruction anyway, so it need not wait.
    stall  = (hazard && !flush) || ex_hold;
  end

  // ---------------------------------------------------------------------
  // ID/EX next state: flush > hold > hazard bubble > load
  // ---------------------------------------------------------------------
  always_comb begin
    idex_d = '0;
    if (flush) begin
      idex_d = '0;
    end else if (ex_hold) begin
      idex_d = idex_q;
    end else if (hazard || !in_valid) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      idex_q <= idex_d;
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign ex_valid     = idex_q.valid;
  assign ex_reg_data1 = idex_q.data1;
  assign ex_reg_data2 = idex_q.data2;
  assign ex_immediate = idex_q.imm;
  assign ex_rs1       = idex_q.rs1;
  assign ex_rs2       = idex_q.rs2;
  assign ex_rd        = idex_q.rd;
  assign ex_funct     = idex_q.funct;
  assign ex_RegWrite  = idex_q.reg_wr;
  assign ex_MemRead   = idex_q.mem_rd;
  assign ex_MemWrite  = idex_q.mem_wr;
  assign ex_MemtoReg  = idex_q.mem_to_reg;
  assign ex_ULASrc    = idex_q.ula_src;
  assign ex_Branch    = idex_q.branch;
  assign ex_ULAOp     = idex_q.ula_op;

endmodule

// File: tb/tb_stage_id_pipe.sv
module tb_stage_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instruction;
  logic        flush;
  logic        ex_hold;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_reg_data1, ex_reg_data2, ex_immediate;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ULASrc, ex_Branch;
  logic [1:0]  ex_ULAOp;

  stage_id_pipe #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instruction(instruction),
    .flush(flush), .ex_hold(ex_hold), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .stall(stall), .ex_valid(ex_valid),
    .ex_reg_data1(ex_reg_data1), .ex_reg_data2(ex_reg_data2), .ex_immediate(ex_immediate),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_ULASrc(ex_ULASrc), .ex_Branch(ex_Branch),
    .ex_ULAOp(ex_ULAOp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // control packing: {RegWrite, MemRead, MemWrite, MemtoReg, ULASrc, Branch, ULAOp}
  typedef struct {
    logic        v;
    logic [31:0] d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
    logic [7:0]  ctrl;
  } ex_t;

  ex_t         m_ex;
  logic [31:0] m_regs [32];
  logic        last_stall;

  localparam logic [31:0] I_ADDI = 32'h00128313; // addi x6,x5,1
  localparam logic [31:0] I_LW   = 32'h0000A383; // lw x7,0(x1)
  localparam logic [31:0] I_ADD  = 32'h00238433; // add x8,x7,x2
  localparam logic [31:0] I_SUB  = 32'h40238433; // sub x8,x7,x2
  localparam logic [31:0] I_ADD9 = 32'h00048533; // add x10,x9,x0
  localparam logic [31:0] I_ADD0 = 32'h00000533; // add x10,x0,x0

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_ctrl();
    return {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ULASrc, ex_Branch, ex_ULAOp};
  endfunction

  function automatic logic [7:0] m_ctrl(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return 8'b1000_0010;
      7'b0000011: return 8'b1101_1000;
      7'b0100011: return 8'b0010_1000;
      7'b1100011: return 8'b0000_0101;
      7'b0010011: return 8'b1000_1011;
      default:    return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int t;
    t = $signed(ins);
    case (ins[6:0])
      7'b0000011, 7'b0010011: return 32'(t >>> 20);
      7'b0100011: return 32'((t >>> 25) * 32 + int'(ins[11:7]));
      7'b1100011: return 32'((t >>> 31) * 4096 + int'(ins[7]) * 2048 +
                             int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
      default:    return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rd_op(input logic [4:0] idx, input logic rw,
                                        input logic [4:0] wr, input logic [31:0] wd);
    if (idx == 0) return 32'h0;
    if (rw && wr == idx) return wd;
    return m_regs[idx];
  endfunction

  task automatic model_reset();
    m_ex = '{default: 0};
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic check_ex(input string tag);
    chk({tag, "_valid"}, {31'h0, ex_valid}, {31'h0, m_ex.v});
    chk({tag, "_ctrl"},  {24'h0, dut_ctrl()}, {24'h0, m_ex.ctrl});
    chk({tag, "_imm"},   ex_immediate, m_ex.imm);
    chk({tag, "_d1"},    ex_reg_data1, m_ex.d1);
    chk({tag, "_d2"},    ex_reg_data2, m_ex.d2);
    chk({tag, "_rs1"},   {27'h0, ex_rs1}, {27'h0, m_ex.rs1});
    chk({tag, "_rs2"},   {27'h0, ex_rs2}, {27'h0, m_ex.rs2});
    chk({tag, "_rd"},    {27'h0, ex_rd}, {27'h0, m_ex.rd});
    chk({tag, "_funct"}, {28'h0, ex_funct}, {28'h0, m_ex.funct});
  endtask

  // One clock: drive inputs, check stall, advance model, check ID/EX.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                       input logic fl, input logic hd, input logic rw,
                       input logic [4:0] wr, input logic [31:0] wd);
    ex_t  nxt;
    logic hz, exp_stall;
    in_valid = iv; instruction = ins; flush = fl; ex_hold = hd;
    reg_write = rw; write_reg = wr; write_data = wd;
    #1;
    hz = m_ex.v && m_ex.ctrl[6] && (m_ex.rd != 0) && iv &&
         ((m_ex.rd == ins[19:15]) || (m_ex.rd == ins[24:20]));
    exp_stall = (hz && !fl) || hd;
    last_stall = stall;
    chk({tag, "_stall"}, {31'h0, stall}, {31'h0, exp_stall});
    if (fl || (!hd && (hz || !iv))) begin
      nxt = '{default: 0};
    end else if (hd) begin
      nxt = m_ex;
    end else begin
      nxt.v     = 1'b1;
      nxt.rs1   = ins[19:15];
      nxt.rs2   = ins[24:20];
      nxt.rd    = ins[11:7];
      nxt.funct = {ins[30], ins[14:12]};
      nxt.ctrl  = m_ctrl(ins);
      nxt.imm   = m_imm(ins);
      nxt.d1    = rd_op(ins[19:15], rw, wr, wd);
      nxt.d2    = rd_op(ins[24:20], rw, wr, wd);
    end
    @(posedge clk);
    #1;
    m_ex = nxt;
    if (rw && wr != 0) m_regs[wr] = wd;
    check_ex(tag);
  endtask

  task automatic idle();
    cycle("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, {31'h0, ex_valid}, 32'h0);
    chk({tag, "_ctrl"}, {24'h0, dut_ctrl()}, 32'h0);
    chk({tag, "_data"}, ex_reg_data1 | ex_reg_data2 | ex_immediate, 32'h0);
    chk({tag, "_idx"}, {17'h0, ex_rs1, ex_rs2, ex_rd}, 32'h0);
    chk({tag, "_funct"}, {28'h0, ex_funct}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] d1;
    logic [3:0]  funct;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{I_ADDI,        8'b1000_1011, 32'h0000_0001, 32'h0000_1234, 4'h0, 5'd6};
    vecs[1] = '{32'hFE000EE3,  8'b0000_0101, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 5'd29};
    vecs[2] = '{I_LW,          8'b1101_1000, 32'h0000_0000, 32'h0000_0100, 4'h2, 5'd7};
    vecs[3] = '{32'hFE20AC23,  8'b0010_1000, 32'hFFFF_FFF8, 32'h0000_0100, 4'hA, 5'd24};
    vecs[4] = '{I_ADD,         8'b1000_0010, 32'h0000_0000, 32'h0000_0000, 4'h0, 5'd8};
    vecs[5] = '{I_SUB,         8'b1000_0010, 32'h0000_0000, 32'h0000_0000, 4'h8, 5'd8};
    vecs[6] = '{32'h0000007F,  8'b0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h0, 5'd0};
    vecs[7] = '{32'h123452B7,  8'b0000_0000, 32'h0000_0000, 32'h0000_0000, 4'h5, 5'd5};

    rst = 1'b1; in_valid = 0; instruction = 0; flush = 0; ex_hold = 0;
    reg_write = 0; write_reg = 0; write_data = 0; last_stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // preload x1, x2, x5
    cycle("pre1", 0, 32'h0, 0, 0, 1, 5'd1, 32'h0000_0100);
    cycle("pre2", 0, 32'h0, 0, 0, 1, 5'd2, 32'h0000_0022);
    cycle("pre5", 0, 32'h0, 0, 0, 1, 5'd5, 32'h0000_1234);

    // x0 ignores writes, including same-cycle write-through
    cycle("x0w", 0, 32'h0, 0, 0, 1, 5'd0, 32'h0000_0005);
    cycle("x0r", 1, I_ADD0, 0, 0, 0, 5'd0, 32'h0);
    chk("x0_read", ex_reg_data1, 32'h0);
    cycle("x0wt", 1, I_ADD0, 0, 0, 1, 5'd0, 32'h0000_0055);
    chk("x0_wt", ex_reg_data1, 32'h0);
    idle();

    // decode table
    for (int i = 0; i < 8; i++) begin
      cycle("vec", 1, vecs[i].ins, 0, 0, 0, 5'd0, 32'h0);
      chk($sformatf("vec%0d_valid", i), {31'h0, ex_valid}, 32'h1);
      chk($sformatf("vec%0d_ctrl", i), {24'h0, dut_ctrl()}, {24'h0, vecs[i].ctrl});
      chk($sformatf("vec%0d_imm", i), ex_immediate, vecs[i].imm);
      chk($sformatf("vec%0d_d1", i), ex_reg_data1, vecs[i].d1);
      chk($sformatf("vec%0d_funct", i), {28'h0, ex_funct}, {28'h0, vecs[i].funct});
      chk($sformatf("vec%0d_rd", i), {27'h0, ex_rd}, {27'h0, vecs[i].rd});
      idle();
    end

    // load-use: one stall cycle, one bubble, then add enters
    cycle("lu_lw", 1, I_LW, 0, 0, 0, 5'd0, 32'h0);
    cycle("lu_add", 1, I_ADD, 0, 0, 0, 5'd0, 32'h0);
    chk("lu_stall", {31'h0, last_stall}, 32'h1);
    chk("lu_bubble", {31'h0, ex_valid}, 32'h0);
    cycle("lu_add2", 1, I_ADD, 0, 0, 0, 5'd0, 32'h0);
    chk("lu_stall2", {31'h0, last_stall}, 32'h0);
    chk("lu_enter", {31'h0, ex_valid}, 32'h1);
    chk("lu_rd", {27'h0, ex_rd}, 32'd8);
    idle();

    // writeback during a hazard commits and is seen on re-decode
    cycle("wbh_lw", 1, I_LW, 0, 0, 0, 5'd0, 32'h0);
    cycle("wbh_add", 1, I_ADD, 0, 0, 1, 5'd2, 32'h0000_0077);
    chk("wbh_stall", {31'h0, last_stall}, 32'h1);
    cycle("wbh_add2", 1, I_ADD, 0, 0, 0, 5'd0, 32'h0);
    chk("wbh_d2", ex_reg_data2, 32'h0000_0077);
    idle();

    // same-cycle writeback forwarding
    cycle("wt", 1, I_ADD9, 0, 0, 1, 5'd9, 32'hDEAD_BEEF);
    chk("wt_d1", ex_reg_data1, 32'hDEAD_BEEF);
    idle();

    // flush beats hazard
    cycle("fl_lw", 1, I_LW, 0, 0, 0, 5'd0, 32'h0);
    cycle("fl_add", 1, I_ADD, 1, 0, 0, 5'd0, 32'h0);
    chk("fl_stall", {31'h0, last_stall}, 32'h0);
    chk("fl_bubble", {31'h0, ex_valid}, 32'h0);

    // hold keeps ID/EX for three cycles even while x5 is rewritten
    cycle("hd_load", 1, I_ADDI, 0, 0, 0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle("hold", 1, I_SUB, 0, 1, 1, 5'd5, 32'h0000_0999 + k);
      chk("hold_stall", {31'h0, last_stall}, 32'h1);
      chk("hold_d1", ex_reg_data1, 32'h0000_1234);
      chk("hold_imm", ex_immediate, 32'h0000_0001);
      chk("hold_ctrl", {24'h0, dut_ctrl()}, 32'h0000_008B);
      chk("hold_rd", {27'h0, ex_rd}, 32'd6);
    end
    idle();

    // asynchronous reset in the middle of a stall
    cycle("rs_lw", 1, I_LW, 0, 0, 0, 5'd0, 32'h0);
    in_valid = 1; instruction = I_ADD;
    #1;
    chk("rs_stall", {31'h0, stall}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rs_async");
    model_reset();
    in_valid = 0; instruction = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rs_add", 1, I_ADD, 0, 0, 0, 5'd0, 32'h0);
    chk("rs_nostall", {31'h0, last_stall}, 32'h0);
    chk("rs_valid", {31'h0, ex_valid}, 32'h1);
    chk("rs_d2", ex_reg_data2, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0]  ops [6];
      ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
      ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b0110111;
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 5)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      cycle("rnd", 1'($urandom_range(0, 9) < 8), ins,
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 2),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
